multicycle_ctrl: RTL

- Multi-cycle control FSM that sequences the shared CPU datapath: instruction/data memory port, ALU, register file, PC and 16→32 immediate extender.
- Latches opcode/funct in DECODE, then steps through FETCH/DECODE/EXEC/MEM/WB.
- Drives the extender's sign/zero select (ExtOp) and all other datapath strobes.
- Handshakes with a variable-latency memory.

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle controller and
// the shared datapath (IR fields, memory handshake and all datapath strobes).
interface multicycle_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       ExtOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUCtr;
  logic       RegDst;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemtoReg;
  logic       instr_done;
  logic       mem_timeout;
  logic       illegal_op;

  // Controller side
  modport master (
    input  run, opcode, funct, mem_ready,
    output mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ExtOp,
           ALUSrcA, ALUSrcB, ALUCtr, RegDst, RegWrite, MemWrite, MemtoReg,
           instr_done, mem_timeout, illegal_op
  );

  // Datapath / memory side
  modport slave (
    output run, opcode, funct, mem_ready,
    input  mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, ExtOp,
           ALUSrcA, ALUSrcB, ALUCtr, RegDst, RegWrite, MemWrite, MemtoReg,
           instr_done, mem_timeout, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the shared CPU
// datapath with a variable-latency memory handshake and a sticky wait timeout.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unsupported instructions in TRAP
// instead of retiring them as NOPs.
module multicycle_ctrl #(
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t            r_state, w_state_next, w_after;
  logic [5:0]        r_op, r_fn;
  logic [WAIT_W-1:0] r_wait, w_wait_next;
  logic              r_timeout;
  logic              w_stall, w_ext_sign, w_decode_legal;

  function automatic logic f_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: f_legal = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW:
        f_legal = 1'b1;
      default:  f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_alu_r(input logic [5:0] fn);
    case (fn)
      FN_SUB:  f_alu_r = ALU_SUB;
      FN_AND:  f_alu_r = ALU_AND;
      FN_OR:   f_alu_r = ALU_OR;
      FN_SLT:  f_alu_r = ALU_SLT;
      default: f_alu_r = ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] f_alu_i(input logic [5:0] op);
    case (op)
      OP_ANDI: f_alu_i = ALU_AND;
      OP_ORI:  f_alu_i = ALU_OR;
      OP_LUI:  f_alu_i = ALU_LUI;
      default: f_alu_i = ALU_ADD;
    endcase
  endfunction

  assign w_decode_legal  = f_legal(bus.opcode, bus.funct);
  assign w_ext_sign      = r_op inside {OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ};
  assign w_after         = bus.run ? S_FETCH : S_IDLE;
  assign w_stall         = ((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_wait_next     = !w_stall ? '0 :
                           (r_wait == WAIT_MAX) ? r_wait : r_wait + WAIT_W'(1);
  assign bus.mem_timeout = r_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Latch the IR opcode/funct while in DECODE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op <= '0;
      r_fn <= '0;
    end else if (r_state == S_DECODE) begin
      r_op <= bus.opcode;
      r_fn <= bus.funct;
    end
  end

  // Saturating memory-wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= w_wait_next;
      if (w_wait_next == WAIT_MAX) r_timeout <= 1'b1;
    end
  end

  // Next-state and datapath strobe decode
  always_comb begin
    w_state_next    = r_state;
    bus.mem_req     = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ExtOp       = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUCtr      = 3'b000;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.run) w_state_next = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.ALUCtr  = ALU_ADD;
        if (bus.mem_ready) begin
          bus.IRWrite  = 1'b1;
          bus.PCWrite  = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp   = 1'b1;
        if (w_decode_legal) begin
          w_state_next = S_EXEC;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          w_state_next = S_TRAP;
`else
          bus.instr_done = 1'b1;
          w_state_next   = w_after;
`endif
        end
      end
      S_EXEC: begin
        bus.ExtOp = w_ext_sign;
        case (r_op)
          OP_RTYPE: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUCtr   = f_alu_r(r_fn);
            w_state_next = S_WB;
          end
          OP_LW, OP_SW: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUSrcB  = 2'b10;
            bus.ALUCtr   = ALU_ADD;
            w_state_next = S_MEM;
          end
          OP_BEQ: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUCtr      = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            bus.instr_done  = 1'b1;
            w_state_next    = w_after;
          end
          OP_J: begin
            bus.PCWrite    = 1'b1;
            bus.PCSource   = 2'b10;
            bus.instr_done = 1'b1;
            w_state_next   = w_after;
          end
          default: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUSrcB  = 2'b10;
            bus.ALUCtr   = f_alu_i(r_op);
            w_state_next = S_WB;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.IorD     = 1'b1;
        bus.ExtOp    = w_ext_sign;
        bus.MemWrite = (r_op == OP_SW);
        if (bus.mem_ready) begin
          if (r_op == OP_SW) begin
            bus.instr_done = 1'b1;
            w_state_next   = w_after;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        bus.ExtOp      = w_ext_sign;
        bus.RegWrite   = 1'b1;
        bus.RegDst     = (r_op == OP_RTYPE);
        bus.MemtoReg   = (r_op == OP_LW);
        bus.instr_done = 1'b1;
        w_state_next   = w_after;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: bus.illegal_op = 1'b1;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
